// File: rtl/prio_level_if.sv
// prio_level_if: bundles the signals between the interrupt arbiter/retire
// logic and the priority-level controller.
//   master : drives irq_req, irq_prio, ret_req, stall;
//            receives irq_ack, level, write_ra_en, depth, err
//   slave  : the controller side (opposite directions)
interface prio_level_if #(
  parameter int PrioNum = 8
);
  localparam int PrioWidth  = $clog2(PrioNum);
  localparam int Depth      = PrioNum - 1;
  localparam int DepthWidth = $clog2(Depth + 1);

  logic                  irq_req;
  logic [PrioWidth-1:0]  irq_prio;
  logic                  ret_req;
  logic                  stall;
  logic                  irq_ack;
  logic [PrioWidth-1:0]  level;
  logic                  write_ra_en;
  logic [DepthWidth-1:0] depth;
  logic                  err;

  modport master (
    output irq_req, irq_prio, ret_req, stall,
    input  irq_ack, level, write_ra_en, depth, err
  );

  modport slave (
    input  irq_req, irq_prio, ret_req, stall,
    output irq_ack, level, write_ra_en, depth, err
  );
endinterface

// File: rtl/prio_level_ctrl.sv
// prio_level_ctrl: interrupt nesting controller. Holds the current execution
// priority level and a stack of preempted levels. An interrupt is taken only
// when its priority strictly exceeds the current level; an interrupt return
// pops the preempted level back.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : prio_level_if.slave
//           in  irq_req, irq_prio, ret_req, stall
//           out irq_ack (1-cycle), level, write_ra_en (1-cycle), depth,
//               err (sticky underflow/overflow)
module prio_level_ctrl #(
  parameter int PrioNum = 8
) (
  input logic          clk,
  input logic          reset,
  prio_level_if.slave  bus
);
  localparam int PrioWidth  = $clog2(PrioNum);
  localparam int Depth      = PrioNum - 1;
  localparam int DepthWidth = $clog2(Depth + 1);

  typedef enum logic [1:0] {RUN, ENTER, RETURN} state_e;

  state_e                state_q, state_d;
  logic [PrioWidth-1:0]  level_q, level_d;
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic                  err_q, err_d;
  logic                  ack_q, ack_d;
  logic                  wra_q, wra_d;
  logic                  push_d;

  // Preempted-level stack; contents need no reset.
  logic [PrioWidth-1:0]  stack_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      level_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      wra_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      wra_q   <= wra_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_d && !reset) begin
      stack_q[depth_q] <= level_q;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    depth_d = depth_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    wra_d   = 1'b0;
    push_d  = 1'b0;
    case (state_q)
      RUN: begin
        // A return outranks a simultaneous interrupt; the interrupt is
        // re-evaluated against the restored level once RUN resumes.
        if (bus.ret_req) begin
          if (depth_q != '0) begin
            level_d = stack_q[depth_q - DepthWidth'(1)];
            depth_d = depth_q - DepthWidth'(1);
            state_d = RETURN;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.irq_req && (bus.irq_prio > level_q) && !bus.stall) begin
          if (depth_q < DepthWidth'(Depth)) begin
            push_d  = 1'b1;
            level_d = bus.irq_prio;
            depth_d = depth_q + DepthWidth'(1);
            ack_d   = 1'b1;
            wra_d   = 1'b1;
            state_d = ENTER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // One-cycle lockouts: requests arriving here are dropped.
      ENTER:   state_d = RUN;
      RETURN:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign bus.level       = level_q;
  assign bus.depth       = depth_q;
  assign bus.err         = err_q;
  assign bus.irq_ack     = ack_q;
  assign bus.write_ra_en = wra_q;
endmodule

// File: tb/tb_prio_level_ctrl.sv
// tb_prio_level_ctrl: directed self-checking bench for prio_level_ctrl.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_prio_level_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prio_level_if #(.PrioNum(8)) bus_if ();

  prio_level_ctrl #(.PrioNum(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lvl, input int dep,
                         input int ack, input int wra, input int er);
    chk({tag, ".level"}, int'(bus_if.level), lvl);
    chk({tag, ".depth"}, int'(bus_if.depth), dep);
    chk({tag, ".irq_ack"}, int'(bus_if.irq_ack), ack);
    chk({tag, ".write_ra_en"}, int'(bus_if.write_ra_en), wra);
    chk({tag, ".err"}, int'(bus_if.err), er);
    $display("t=%0t %s: level=%0d depth=%0d ack=%0d wra=%0d err=%0d", $time, tag,
             bus_if.level, bus_if.depth, bus_if.irq_ack, bus_if.write_ra_en, bus_if.err);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus_if.irq_req  = 1'b0;
    bus_if.irq_prio = 3'd0;
    bus_if.ret_req  = 1'b0;
    bus_if.stall    = 1'b0;

    // Reset and idle
    step(); step();
    chk_all("in_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (5) step();
    chk_all("idle", 0, 0, 0, 0, 0);

    // Single entry then return
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd3;
    step(); chk_all("enter3", 3, 1, 1, 1, 0);
    bus_if.irq_req = 1'b0;
    step(); chk_all("enter3_lock", 3, 1, 0, 0, 0);
    bus_if.ret_req = 1'b1;
    step(); chk_all("ret_to0", 0, 0, 0, 0, 0);
    bus_if.ret_req = 1'b0;
    step();

    // Nesting 2 -> 5 -> 7
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd2;
    step(); chk_all("enter2", 2, 1, 1, 1, 0);
    bus_if.irq_req = 1'b0; step();
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd5;
    step(); chk_all("enter5", 5, 2, 1, 1, 0);
    bus_if.irq_req = 1'b0; step();
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd7;
    step(); chk_all("enter7", 7, 3, 1, 1, 0);
    bus_if.irq_req = 1'b0; step();

    // Equal priority is never taken
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd7;
    step(); chk_all("equal7_a", 7, 3, 0, 0, 0);
    step(); chk_all("equal7_b", 7, 3, 0, 0, 0);
    bus_if.irq_req = 1'b0;

    // Unwind
    bus_if.ret_req = 1'b1;
    step(); chk_all("ret_to5", 5, 2, 0, 0, 0);
    bus_if.ret_req = 1'b0; step();
    bus_if.ret_req = 1'b1;
    step(); chk_all("ret_to2", 2, 1, 0, 0, 0);
    bus_if.ret_req = 1'b0; step();

    // Lower priority while at level 2
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd1;
    step(); chk_all("lower1_a", 2, 1, 0, 0, 0);
    step(); chk_all("lower1_b", 2, 1, 0, 0, 0);
    bus_if.irq_req = 1'b0;
    bus_if.ret_req = 1'b1;
    step(); chk_all("ret_to0b", 0, 0, 0, 0, 0);
    bus_if.ret_req = 1'b0; step();

    // Stall blocks entry
    bus_if.stall = 1'b1; bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stalled", 0, 0, 0, 0, 0);
    end
    bus_if.stall = 1'b0;
    step(); chk_all("enter4", 4, 1, 1, 1, 0);
    bus_if.irq_req = 1'b0; step();

    // Simultaneous return and interrupt: return wins, then tail-chain
    bus_if.ret_req = 1'b1; bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd6;
    step(); chk_all("simul_ret", 0, 0, 0, 0, 0);
    bus_if.ret_req = 1'b0;
    step(); chk_all("simul_lock", 0, 0, 0, 0, 0);
    step(); chk_all("tail_enter6", 6, 1, 1, 1, 0);
    bus_if.irq_req = 1'b0; step();
    bus_if.ret_req = 1'b1;
    step(); chk_all("ret_from6", 0, 0, 0, 0, 0);
    bus_if.ret_req = 1'b0; step();

    // Underflow: sticky err
    bus_if.ret_req = 1'b1;
    step(); chk_all("underflow", 0, 0, 0, 0, 1);
    bus_if.ret_req = 1'b0; step();
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd5;
    step(); chk_all("err_sticky_enter", 5, 1, 1, 1, 1);
    bus_if.irq_req = 1'b0; step();
    bus_if.ret_req = 1'b1;
    step(); chk_all("err_sticky_ret", 0, 0, 0, 0, 1);
    bus_if.ret_req = 1'b0; step();

    // Asynchronous reset in the middle of ENTER (level 5, depth 2)
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd3;
    step(); chk_all("pre_enter3", 3, 1, 1, 1, 1);
    bus_if.irq_req = 1'b0; step();
    bus_if.irq_req = 1'b1; bus_if.irq_prio = 3'd5;
    step(); chk_all("mid_enter5", 5, 2, 1, 1, 1);
    bus_if.irq_req = 1'b0;
    #2 reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    step(); step();
    chk_all("reset_held", 0, 0, 0, 0, 0);
    reset = 1'b0;
    step(); chk_all("post_reset", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
